// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ULA family.
//   - 4-bit opcode constants for the combinational ops and the mult/div ops
//   - FSM state enum of the multi-cycle unit
//   - small opcode classification helpers
package ula_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_NOR   = 4'h5;
  localparam logic [3:0] ALU_SLT   = 4'h6;
  localparam logic [3:0] ALU_SLTU  = 4'h7;
  localparam logic [3:0] ALU_SLL   = 4'h8;
  localparam logic [3:0] ALU_SRL   = 4'h9;
  localparam logic [3:0] ALU_SRA   = 4'hA;
  localparam logic [3:0] ALU_LUI   = 4'hB;
  localparam logic [3:0] ALU_MULT  = 4'hC;
  localparam logic [3:0] ALU_MULTU = 4'hD;
  localparam logic [3:0] ALU_DIV   = 4'hE;
  localparam logic [3:0] ALU_DIVU  = 4'hF;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_signed_md(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// ula_muldiv_iter: iterative unsigned multiply/divide datapath.
//   load     : latch operand magnitudes, clear accumulator, arm the counter
//   step     : perform one iteration (shift-add or restoring shift-subtract)
//   sel_div  : 1 = divide, 0 = multiply (sampled on load)
//   opa/opb  : multiplier/dividend and multiplicand/divisor magnitudes
//   acc/quo  : after WIDTH steps, {acc,quo} = product, or acc = remainder,
//              quo = quotient
//   last     : the current step is the final one
module ula_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             sel_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo,
  output logic             last
);
  localparam int SHW = $clog2(WIDTH);

  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] m;
  logic             div_mode;
  logic [WIDTH:0]   sum, shl, diff;

  always_comb begin
    // multiply: add multiplicand when the multiplier LSB is set
    sum  = {1'b0, acc} + (quo[0] ? {1'b0, m} : '0);
    // divide: bring the next dividend bit into the partial remainder;
    // diff[WIDTH] is the borrow, i.e. partial remainder < divisor
    shl  = {acc, quo[WIDTH-1]};
    diff = shl - {1'b0, m};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      m        <= '0;
      acc      <= '0;
      quo      <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      cnt      <= (SHW+1)'(WIDTH);
      m        <= opb;
      acc      <= '0;
      quo      <= opa;
      div_mode <= sel_div;
    end else if (step) begin
      cnt <= cnt - 1'b1;
      if (div_mode) begin
        if (!diff[WIDTH]) begin
          acc <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          acc <= shl[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= sum[WIDTH:1];
        quo <= {sum[0], quo[WIDTH-1:1]};
      end
    end
  end

  assign last = (cnt == (SHW+1)'(1));

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU with registered results.
//   clk, rst_n   : clock, async active-low reset
//   start, op    : request strobe (taken only while idle) and opcode
//   in_a, in_b   : operands (in_a = dividend / shift amount, in_b = divisor / shifted data)
//   result       : registered result (= lo for mult/div)
//   hi, lo       : product upper/lower half, or remainder/quotient
//   zero         : result == 0
//   busy         : mult/div in progress
//   done         : one-cycle pulse when outputs update
//   div_by_zero  : pulses with done for DIV/DIVU by zero
import ula_pkg::*;

module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic             accept, md, dv, sgn, sa, sb, dbz_now, load, last;
  logic             neg_q, neg_r, div_op;
  logic [WIDTH-1:0] alu_y, a_mag, b_mag, it_acc, it_quo, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [SHW-1:0]   shamt;

  assign busy    = (state != IDLE);
  assign accept  = start && !busy;
  assign md      = is_muldiv(op);
  assign dv      = is_div(op);
  assign sgn     = is_signed_md(op);
  assign sa      = sgn && in_a[WIDTH-1];
  assign sb      = sgn && in_b[WIDTH-1];
  assign a_mag   = sa ? -in_a : in_a;
  assign b_mag   = sb ? -in_b : in_b;
  assign dbz_now = dv && (in_b == '0);
  assign load    = accept && md && !dbz_now;
  assign shamt   = in_a[SHW-1:0];
  assign zero    = (result == '0);

  always_comb begin
    alu_y = '0;
    case (op)
      ALU_ADD:  alu_y = in_a + in_b;
      ALU_SUB:  alu_y = in_a - in_b;
      ALU_AND:  alu_y = in_a & in_b;
      ALU_OR:   alu_y = in_a | in_b;
      ALU_XOR:  alu_y = in_a ^ in_b;
      ALU_NOR:  alu_y = ~(in_a | in_b);
      ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, in_a < in_b};
      ALU_SLL:  alu_y = in_b << shamt;
      ALU_SRL:  alu_y = in_b >> shamt;
      ALU_SRA:  alu_y = $signed(in_b) >>> shamt;
      ALU_LUI:  alu_y = {in_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:  alu_y = '0;
    endcase
  end

  ula_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (state == ITER),
    .sel_div (dv),
    .opa     (a_mag),
    .opb     (b_mag),
    .acc     (it_acc),
    .quo     (it_quo),
    .last    (last)
  );

  // Sign correction: truncating division, remainder follows the dividend.
  // MIN / -1 yields quotient MIN with no negation since both signs are set.
  assign prod_fix = neg_q ? -{it_acc, it_quo} : {it_acc, it_quo};
  assign quo_fix  = neg_q ? -it_quo : it_quo;
  assign rem_fix  = neg_r ? -it_acc : it_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = ITER;
      ITER:    if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_op      <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (load) begin
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        div_op <= dv;
      end
      if (accept && !md) begin
        result <= alu_y;
        done   <= 1'b1;
      end else if (accept && dbz_now) begin
        lo          <= '1;
        hi          <= in_a;
        result      <= '1;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end else if (state == FIX) begin
        if (div_op) begin
          lo     <= quo_fix;
          hi     <= rem_fix;
          result <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
          result   <= prod_fix[WIDTH-1:0];
        end
        done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Multi-cycle successor to the single-cycle ULA, parametrised in datapath width.
- Keeps all 12 existing combinational operations, with the result registered.
- Adds iterative signed/unsigned multiply and divide, with HI/LO outputs for MULT/MULTU/DIV/DIVU.
- Sits in the EX stage next to the existing ULA. The control unit stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, datapath width. Must be even and >= 8.
- SHW, $clog2(WIDTH), derived localparam: shift-amount width. Not overridable.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; accepted only when busy=0.
- op  in  4  operation code.
- in_a  in  WIDTH  operand 1 (dividend / shift amount source).
- in_b  in  WIDTH  operand 2 (divisor / shifted data).
- result  out  WIDTH  registered result (LO for mult/div ops).
- hi  out  WIDTH  upper product / remainder.
- lo  out  WIDTH  lower product / quotient.
- zero  out  1  result == 0.
- busy  out  1  high while a mult/div is iterating.
- done  out  1  one-cycle pulse when result/hi/lo are updated.
- div_by_zero  out  1  set with done when DIV/DIVU has in_b == 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result, hi, lo, busy, done and div_by_zero all 0; zero=1.
  - Reset mid-operation aborts the operation; no done is produced.
- Opcodes 0x0-0xB: same as the existing ULA: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI.
  - Shifts use in_a[SHW-1:0] as the amount.
  - LUI produces {in_b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- New opcodes: 0xC MULT (signed), 0xD MULTU, 0xE DIV (signed), 0xF DIVU.
- Single-cycle ops: start in cycle N -> result/zero valid and done=1 in cycle N+1. busy stays 0. hi/lo unchanged.
- Mult/div FSM: IDLE -> ITER -> FIX -> IDLE.
  - Start in cycle N: operands are latched and converted to magnitudes (signed ops). busy=1 from N+1.
  - ITER runs exactly WIDTH cycles: shift-add for multiply, restoring shift-subtract for divide. An internal counter of width SHW+1 counts down.
  - FIX: one cycle applying sign correction.
    - Product is negated if operand signs differ.
    - Quotient is negated if signs differ; remainder takes the dividend's sign (truncation toward zero).
  - hi, lo, result (=lo), zero and done update in cycle N+WIDTH+2; busy drops in that same cycle.
- Divide by zero: no iteration. In cycle N+1: lo=all ones, hi=in_a, result=lo, div_by_zero=1, done=1.
- Signed DIV of MIN by -1: lo=MIN, hi=0, no flag; this falls out of the magnitude algorithm.
- div_by_zero and done are single-cycle pulses, 0 otherwise.
- start while busy=1 is ignored: no queuing, no effect on the current operation.
- start in the cycle busy falls is accepted; back-to-back operations are legal.
- Outputs hold their last values between completions.
- Operands are sampled only at acceptance; in_a/in_b may change during ITER.

Decomposition:
- Shared package ula_pkg holds:
  - the 4-bit opcode constants (ALU_ADD..ALU_LUI, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU);
  - the FSM state enum (IDLE, ITER, FIX).
  - The existing ULA and ULA Control migrate to the same package.
- One natural sub-module: ula_muldiv_iter, the iterative shift-add/shift-subtract datapath with its counter. The top level holds the single-cycle ops, sign handling and output registers.

Test Plan:
- ADD 0x7FFFFFFF + 1, then SUB 5-5 -> result 0x80000000, done at N+1, busy=0; then result 0, zero=1.
- MULT in_a=-3 (0xFFFFFFFD), in_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly at N+34, busy high cycles N+1..N+33.
- DIV in_a=-7, in_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
- DIVU in_b=0, in_a=0x1234 -> done and div_by_zero at N+1, lo=0xFFFFFFFF, hi=0x1234, busy never rises.
- Pulse start with ADD during a MULTU busy window -> ignored: one done only, MULTU result correct. Then start SLL (in_a=4, in_b=1) in the cycle busy falls -> result 0x10 one cycle later.
- Assert rst_n=0 at iteration 10 of a DIV -> all outputs 0 immediately, zero=1, no done. After release, a new MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
